// File: rtl/nfu3_activation_if.sv
// Stream + segment-table configuration bundle for the NFU-3 activation stage.
// The slave modport is the stage itself; the master modport is whoever feeds
// beats in, drains results and programs the segment table.
interface nfu3_activation_if #(
  parameter int BIT_WIDTH     = 16,
  parameter int Tn            = 16,
  parameter int SEG_SEL_WIDTH = 4
);
  logic                        i_valid;
  logic                        o_ready;
  logic [Tn*BIT_WIDTH-1:0]     i_data;
  logic                        i_final;
  logic                        o_valid;
  logic                        i_ready;
  logic [Tn*BIT_WIDTH-1:0]     o_data;
  logic                        o_final;
  logic                        i_cfg_we;
  logic [SEG_SEL_WIDTH-1:0]    i_cfg_addr;
  logic [BIT_WIDTH-1:0]        i_cfg_a;
  logic [BIT_WIDTH-1:0]        i_cfg_b;

  modport master (
    output i_valid, i_data, i_final, i_ready,
    output i_cfg_we, i_cfg_addr, i_cfg_a, i_cfg_b,
    input  o_ready, o_valid, o_data, o_final
  );

  modport slave (
    input  i_valid, i_data, i_final, i_ready,
    input  i_cfg_we, i_cfg_addr, i_cfg_a, i_cfg_b,
    output o_ready, o_valid, o_data, o_final
  );
endinterface

// File: rtl/nfu3_activation.sv
// NFU-3 activation stage.
// Three-stage pipeline: S1 captures x and derives the segment index, S2 looks
// up (a,b) and forms a*x, S3 applies the shift, adds b and saturates.  Non-final
// beats carry x through untouched with the same latency.  A single shared
// 16-entry segment table serves all lanes; writes bypass the stall logic.
module nfu3_activation #(
  parameter int BIT_WIDTH     = 16,
  parameter int Tn            = 16,
  parameter int FRAC_BITS     = 8,
  parameter int SEG_SEL_WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  nfu3_activation_if.slave   bus
);

  localparam int NUM_SEG = 1 << SEG_SEL_WIDTH;
  localparam int PW      = 2 * BIT_WIDTH;
  localparam int SW      = PW + 1;

  // Identity slope 1.0 in Q(FRAC_BITS).
  localparam logic signed [BIT_WIDTH-1:0] A_ONE_C =
    {{(BIT_WIDTH-FRAC_BITS-1){1'b0}}, 1'b1, {FRAC_BITS{1'b0}}};
  localparam logic signed [BIT_WIDTH-1:0] ZERO_C = {BIT_WIDTH{1'b0}};
  localparam logic signed [BIT_WIDTH-1:0] OUT_MAX_C = {1'b0, {(BIT_WIDTH-1){1'b1}}};
  localparam logic signed [BIT_WIDTH-1:0] OUT_MIN_C = {1'b1, {(BIT_WIDTH-1){1'b0}}};
  localparam logic signed [SW-1:0] SAT_MAX_C = {{(SW-BIT_WIDTH+1){1'b0}}, {(BIT_WIDTH-1){1'b1}}};
  localparam logic signed [SW-1:0] SAT_MIN_C = {{(SW-BIT_WIDTH+1){1'b1}}, {(BIT_WIDTH-1){1'b0}}};

  // Flow control
  logic en_s;

  // Input unpack
  logic signed [BIT_WIDTH-1:0]     x_in_s   [Tn];
  logic        [SEG_SEL_WIDTH-1:0] idx_in_s [Tn];

  // Stage 1
  logic                            s1_valid_r;
  logic                            s1_final_r;
  logic signed [BIT_WIDTH-1:0]     s1_x_r   [Tn];
  logic        [SEG_SEL_WIDTH-1:0] s1_idx_r [Tn];

  // Segment table
  logic signed [BIT_WIDTH-1:0]     a_tab_r [NUM_SEG];
  logic signed [BIT_WIDTH-1:0]     b_tab_r [NUM_SEG];

  // Stage 2
  logic signed [BIT_WIDTH-1:0]     a_sel_s  [Tn];
  logic signed [BIT_WIDTH-1:0]     b_sel_s  [Tn];
  logic signed [PW-1:0]            prod_s   [Tn];
  logic                            s2_valid_r;
  logic                            s2_final_r;
  logic signed [PW-1:0]            s2_prod_r [Tn];
  logic signed [BIT_WIDTH-1:0]     s2_x_r    [Tn];
  logic signed [BIT_WIDTH-1:0]     s2_b_r    [Tn];

  // Stage 3
  logic signed [PW-1:0]            shift_s [Tn];
  logic signed [SW-1:0]            sum_s   [Tn];
  logic signed [BIT_WIDTH-1:0]     act_s   [Tn];
  logic        [Tn*BIT_WIDTH-1:0]  res_s;
  logic                            o_valid_r;
  logic                            o_final_r;
  logic        [Tn*BIT_WIDTH-1:0]  o_data_r;

  // Whole pipeline advances unless a valid output is being held back.
  always_comb begin
    en_s = ~o_valid_r | bus.i_ready;
  end

  assign bus.o_ready = en_s;
  assign bus.o_valid = o_valid_r;
  assign bus.o_data  = o_data_r;
  assign bus.o_final = o_final_r;

  // Split the input bus into lanes and form the monotonic segment index.
  always_comb begin
    for (int k = 0; k < Tn; k++) begin
      x_in_s[k]   = bus.i_data[k*BIT_WIDTH +: BIT_WIDTH];
      idx_in_s[k] = {~x_in_s[k][BIT_WIDTH-1], x_in_s[k][BIT_WIDTH-2 -: SEG_SEL_WIDTH-1]};
    end
  end

  // S1: capture x, final flag and segment index.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid_r <= 1'b0;
      s1_final_r <= 1'b0;
      for (int k = 0; k < Tn; k++) begin
        s1_x_r[k]   <= ZERO_C;
        s1_idx_r[k] <= {SEG_SEL_WIDTH{1'b0}};
      end
    end else if (en_s) begin
      s1_valid_r <= bus.i_valid;
      s1_final_r <= bus.i_final;
      for (int k = 0; k < Tn; k++) begin
        s1_x_r[k]   <= x_in_s[k];
        s1_idx_r[k] <= idx_in_s[k];
      end
    end
  end

  // Segment table: reset to identity, written on any edge regardless of stalls.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_SEG; i++) begin
        a_tab_r[i] <= A_ONE_C;
        b_tab_r[i] <= ZERO_C;
      end
    end else if (bus.i_cfg_we) begin
      a_tab_r[bus.i_cfg_addr] <= bus.i_cfg_a;
      b_tab_r[bus.i_cfg_addr] <= bus.i_cfg_b;
    end
  end

  // Table lookup (pre-edge contents, so a same-cycle write is not seen) and slope multiply.
  always_comb begin
    for (int k = 0; k < Tn; k++) begin
      a_sel_s[k] = a_tab_r[s1_idx_r[k]];
      b_sel_s[k] = b_tab_r[s1_idx_r[k]];
      prod_s[k]  = PW'(a_sel_s[k]) * PW'(s1_x_r[k]);
    end
  end

  // S2: register product, intercept and the raw x for pass-through beats.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s2_valid_r <= 1'b0;
      s2_final_r <= 1'b0;
      for (int k = 0; k < Tn; k++) begin
        s2_prod_r[k] <= {PW{1'b0}};
        s2_x_r[k]    <= ZERO_C;
        s2_b_r[k]    <= ZERO_C;
      end
    end else if (en_s) begin
      s2_valid_r <= s1_valid_r;
      s2_final_r <= s1_final_r;
      for (int k = 0; k < Tn; k++) begin
        s2_prod_r[k] <= prod_s[k];
        s2_x_r[k]    <= s1_x_r[k];
        s2_b_r[k]    <= b_sel_s[k];
      end
    end
  end

  // Rescale (floor shift), add intercept, saturate; pick activation or pass-through.
  always_comb begin
    res_s = {(Tn*BIT_WIDTH){1'b0}};
    for (int k = 0; k < Tn; k++) begin
      shift_s[k] = s2_prod_r[k] >>> FRAC_BITS;
      sum_s[k]   = SW'(shift_s[k]) + SW'(s2_b_r[k]);
      if (sum_s[k] > SAT_MAX_C) begin
        act_s[k] = OUT_MAX_C;
      end else if (sum_s[k] < SAT_MIN_C) begin
        act_s[k] = OUT_MIN_C;
      end else begin
        act_s[k] = sum_s[k][BIT_WIDTH-1:0];
      end
      if (s2_final_r) begin
        res_s[k*BIT_WIDTH +: BIT_WIDTH] = act_s[k];
      end else begin
        res_s[k*BIT_WIDTH +: BIT_WIDTH] = s2_x_r[k];
      end
    end
  end

  // S3: output register, held while the downstream stalls.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      o_valid_r <= 1'b0;
      o_final_r <= 1'b0;
      o_data_r  <= {(Tn*BIT_WIDTH){1'b0}};
    end else if (en_s) begin
      o_valid_r <= s2_valid_r;
      o_final_r <= s2_final_r;
      o_data_r  <= res_s;
    end
  end

endmodule

// File: tb/tb_nfu3_activation.sv
// Scoreboard bench for nfu3_activation: stimulus pushes expected beats,
// an independent monitor pops and compares on every output handshake.
module tb_nfu3_activation;

  localparam int BW  = 16;
  localparam int TN  = 16;
  localparam int SEG = 4;
  localparam int DW  = BW * TN;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  nfu3_activation_if #(.BIT_WIDTH(BW), .Tn(TN), .SEG_SEL_WIDTH(SEG)) bus ();

  nfu3_activation #(
    .BIT_WIDTH(BW), .Tn(TN), .FRAC_BITS(8), .SEG_SEL_WIDTH(SEG)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [DW-1:0] data;
    logic          fin;
    int            cyc;
    bit            lat;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic          prev_stall = 1'b0;
  logic [DW-1:0] prev_data;
  logic          prev_final;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [DW-1:0] rep(input logic [BW-1:0] x);
    logic [DW-1:0] v;
    for (int k = 0; k < TN; k++) v[k*BW +: BW] = x;
    return v;
  endfunction

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Entered at posedge+1; returns at posedge+1 right after the accepting edge.
  task automatic send(input logic [DW-1:0] data, input logic fin,
                      input logic [DW-1:0] expd, input bit lat, input bit push);
    int n;
    exp_t e;
    n = 0;
    bus.i_valid = 1'b1;
    bus.i_data  = data;
    bus.i_final = fin;
    #1;
    while (!bus.o_ready && n < 100) begin
      @(posedge clk);
      #2;
      n++;
    end
    if (!bus.o_ready) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout actual=stalled required=o_ready");
    end
    if (push) begin
      e.data = expd;
      e.fin  = fin;
      e.cyc  = cyc;
      e.lat  = lat;
      exp_q.push_back(e);
    end
    @(posedge clk);
    #1;
    bus.i_valid = 1'b0;
  endtask

  task automatic cfg(input logic [SEG-1:0] addr, input logic [BW-1:0] a, input logic [BW-1:0] b);
    bus.i_cfg_we   = 1'b1;
    bus.i_cfg_addr = addr;
    bus.i_cfg_a    = a;
    bus.i_cfg_b    = b;
    @(posedge clk);
    #1;
    bus.i_cfg_we   = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout actual=%0d pending required=0", exp_q.size());
      exp_q.delete();
    end
    @(posedge clk);
    #1;
  endtask

  // Monitor: compare on every output handshake and track held data while stalled.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          chk("stall_hold_valid", DW'(bus.o_valid), DW'(1'b1));
          chk("stall_hold_data", bus.o_data, prev_data);
          chk("stall_hold_final", DW'(bus.o_final), DW'(prev_final));
        end
        if (bus.o_valid && !bus.i_ready) begin
          chk("o_ready_stalled", DW'(bus.o_ready), DW'(1'b0));
          prev_stall = 1'b1;
          prev_data  = bus.o_data;
          prev_final = bus.o_final;
        end else begin
          prev_stall = 1'b0;
        end
        if (bus.o_valid && bus.i_ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_beat actual=%h required=none", bus.o_data);
          end else begin
            e = exp_q.pop_front();
            chk("beat_data", bus.o_data, e.data);
            chk("beat_final", DW'(bus.o_final), DW'(e.fin));
            if (e.lat) chk("latency", DW'(cyc - e.cyc), DW'(3));
          end
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1);
  end

  initial begin
    logic [DW-1:0] mix_in;
    logic [DW-1:0] mix_exp;
    bus.i_valid    = 1'b0;
    bus.i_data     = '0;
    bus.i_final    = 1'b0;
    bus.i_ready    = 1'b1;
    bus.i_cfg_we   = 1'b0;
    bus.i_cfg_addr = 4'd0;
    bus.i_cfg_a    = 16'h0000;
    bus.i_cfg_b    = 16'h0000;

    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("reset_o_valid", DW'(bus.o_valid), DW'(1'b0));
    chk("reset_o_data", bus.o_data, '0);
    chk("reset_o_final", DW'(bus.o_final), DW'(1'b0));
    chk("reset_o_ready", DW'(bus.o_ready), DW'(1'b1));

    // 1: identity table after reset, latency 3
    send(rep(16'h0100), 1'b1, rep(16'h0100), 1'b1, 1'b1);
    send(rep(16'hFF80), 1'b1, rep(16'hFF80), 1'b1, 1'b1);
    drain();

    // 2: constant segment at idx 8, neighbour idx 7 still identity, lanes independent, floor shift
    cfg(4'd8, 16'h0000, 16'h0080);
    send(rep(16'h0100), 1'b1, rep(16'h0080), 1'b0, 1'b1);
    send(rep(16'hF000), 1'b1, rep(16'hF000), 1'b0, 1'b1);
    for (int k = 0; k < TN; k++) begin
      mix_in[k*BW +: BW]  = (k % 2 == 0) ? 16'h0100 : 16'hF000;
      mix_exp[k*BW +: BW] = (k % 2 == 0) ? 16'h0080 : 16'hF000;
    end
    send(mix_in, 1'b1, mix_exp, 1'b0, 1'b1);
    cfg(4'd7, 16'h0180, 16'h0000);
    send(rep(16'hFFFF), 1'b1, rep(16'hFFFE), 1'b0, 1'b1);
    drain();

    // 3: same-cycle write sees old entry, then saturation both ways
    send(rep(16'h7000), 1'b1, rep(16'h7000), 1'b0, 1'b1);
    cfg(4'd15, 16'h7FFF, 16'h7FFF);
    send(rep(16'h7000), 1'b1, rep(16'h7FFF), 1'b0, 1'b1);
    cfg(4'd0, 16'h7FFF, 16'h0000);
    send(rep(16'h8000), 1'b1, rep(16'h8000), 1'b0, 1'b1);
    drain();

    // 4: six-beat stream with a four-cycle downstream stall
    fork
      begin
        for (int i = 1; i <= 6; i++) begin
          send(rep(16'(i * 16'h1000)), 1'b1, rep(16'(i * 16'h1000)), 1'b0, 1'b1);
        end
      end
      begin
        repeat (3) @(posedge clk);
        #1;
        bus.i_ready = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        bus.i_ready = 1'b1;
      end
    join
    drain();

    // 5: pass-through beats interleaved with activated ones
    cfg(4'd9, 16'h0000, 16'h0000);
    send(rep(16'h1234), 1'b0, rep(16'h1234), 1'b0, 1'b1);
    send(rep(16'h1234), 1'b1, rep(16'h0000), 1'b0, 1'b1);
    send(rep(16'h1234), 1'b0, rep(16'h1234), 1'b0, 1'b1);
    send(rep(16'h0100), 1'b1, rep(16'h0080), 1'b0, 1'b1);
    drain();

    // 6: reset with three beats in flight
    bus.i_ready = 1'b0;
    send(rep(16'h0100), 1'b1, '0, 1'b0, 1'b0);
    send(rep(16'h7000), 1'b1, '0, 1'b0, 1'b0);
    send(rep(16'h1234), 1'b0, '0, 1'b0, 1'b0);
    rst_n = 1'b0;
    bus.i_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("midreset_o_valid", DW'(bus.o_valid), DW'(1'b0));
    chk("midreset_o_data", bus.o_data, '0);
    chk("midreset_o_final", DW'(bus.o_final), DW'(1'b0));
    rst_n = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    chk("post_reset_idle", DW'(bus.o_valid), DW'(1'b0));
    send(rep(16'h7000), 1'b1, rep(16'h7000), 1'b0, 1'b1);
    send(rep(16'h0100), 1'b1, rep(16'h0100), 1'b0, 1'b1);
    send(rep(16'h8000), 1'b1, rep(16'h8000), 1'b0, 1'b1);
    drain();

    chk("queue_empty", DW'(exp_q.size()), DW'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
